mul_div_unit: RTL and testbench



---
 rtl/mul_div_if.sv | 28 ++
 rtl/mul_div_unit.sv | 181 ++++++++++++++++++
 tb/tb_mul_div_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mul_div_if.sv
// Operand/result bundle between the issue logic and mul_div_unit.
// When MDU_ABORT_EN is defined, the bundle also carries an abort request.
interface mul_div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;
`ifdef MDU_ABORT_EN
    logic             abort;

    modport master (output start, op, opa, opb, abort,
                    input  busy, done, hi, lo, div_by_zero);
    modport slave  (input  start, op, opa, opb, abort,
                    output busy, done, hi, lo, div_by_zero);
`else
    modport master (output start, op, opa, opb,
                    input  busy, done, hi, lo, div_by_zero);
    modport slave  (input  start, op, opa, opb,
                    output busy, done, hi, lo, div_by_zero);
`endif
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one result bit per clock, HI/LO result registers.
// Optional macro MDU_ABORT_EN adds an abort input that cancels CALC/SIGN.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    mul_div_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_SIGN = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   magb_q, magb_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_shift_s;
    logic [WIDTH:0]     div_diff_s;
    logic [2*WIDTH-1:0] prod_s;
    logic               abort_s;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

`ifdef MDU_ABORT_EN
    assign abort_s = bus.abort && ((state_q == ST_CALC) || (state_q == ST_SIGN));
`else
    assign abort_s = 1'b0;
`endif

    // Multiply step adds B when the multiplier LSB is set; divide step is a restoring trial subtract.
    assign mul_sum_s   = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? magb_q : WIDTH'(0))};
    assign div_shift_s = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_diff_s  = div_shift_s - {1'b0, magb_q};
    assign prod_s      = neg_res_q ? (~{acc_hi_q, acc_lo_q} + (2*WIDTH)'(1)) : {acc_hi_q, acc_lo_q};

    // Next-state, datapath iteration and result write-back.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        opa_d     = opa_q;
        magb_d    = magb_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dbz_d     = dbz_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d   = ST_CALC;
                    cnt_d     = CW'(0);
                    is_div_d  = bus.op[1];
                    neg_res_d = bus.op[0] && (bus.opa[WIDTH-1] ^ bus.opb[WIDTH-1]);
                    neg_rem_d = bus.op[0] && bus.opa[WIDTH-1];
                    dz_d      = bus.op[1] && (bus.opb == WIDTH'(0));
                    opa_d     = bus.opa;
                    magb_d    = magnitude(bus.opb, bus.op[0]);
                    acc_hi_d  = WIDTH'(0);
                    acc_lo_d  = magnitude(bus.opa, bus.op[0]);
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (is_div_q) begin
                    acc_hi_d = div_diff_s[WIDTH] ? div_shift_s[WIDTH-1:0] : div_diff_s[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], ~div_diff_s[WIDTH]};
                end else begin
                    acc_hi_d = mul_sum_s[WIDTH:1];
                    acc_lo_d = {mul_sum_s[0], acc_lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d = ST_SIGN;
                end else begin
                    state_d = ST_CALC;
                end
            end
            ST_SIGN: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
                dbz_d   = dz_q;
                if (!is_div_q) begin
                    hi_d = prod_s[2*WIDTH-1:WIDTH];
                    lo_d = prod_s[WIDTH-1:0];
                end else if (dz_q) begin
                    hi_d = opa_q;
                    lo_d = {WIDTH{1'b1}};
                end else begin
                    hi_d = cond_neg(acc_hi_q, neg_rem_q);
                    lo_d = cond_neg(acc_lo_q, neg_res_q);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Abort cancels the operation without touching the architectural results.
        if (abort_s) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
            dbz_d   = dbz_q;
        end else begin
            state_d = state_d;
        end
        busy_d = (state_d == ST_CALC) || (state_d == ST_SIGN);
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= CW'(0);
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            opa_q     <= WIDTH'(0);
            magb_q    <= WIDTH'(0);
            acc_hi_q  <= WIDTH'(0);
            acc_lo_q  <= WIDTH'(0);
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= WIDTH'(0);
            lo_q      <= WIDTH'(0);
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            opa_q     <= opa_d;
            magb_q    <= magb_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            dbz_q     <= dbz_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit (WIDTH=32); abort steps run only with MDU_ABORT_EN.
module tb_mul_div_unit;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   cyc;
    int   t_start;
    int   t_done;
    int   t_done_prev;
    int   saw_done;

    mul_div_if #(.WIDTH(32)) bus ();

    mul_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives start for one edge; sync=1 aligns to the negedge first, sync=0 drives immediately.
    task automatic launch(input bit sync, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (sync) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.opa   = a;
        bus.opb   = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        t_start   = cyc;
    endtask

    task automatic wait_done(output int t);
        while (bus.done !== 1'b1 && (cyc - t_start) < 100) begin
            @(posedge clk);
            #1;
        end
        t = cyc;
    endtask

    task automatic run_check(input string tag, input logic [1:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                             input logic edz);
        launch(1'b1, op, a, b);
        wait_done(t_done);
        check({tag, "_lat"}, 64'(t_done - t_start), 64'd33);
        check({tag, "_hi"}, {32'd0, bus.hi}, {32'd0, ehi});
        check({tag, "_lo"}, {32'd0, bus.lo}, {32'd0, elo});
        check({tag, "_dz"}, {63'd0, bus.div_by_zero}, {63'd0, edz});
    endtask

    task automatic watch_no_done(input int n);
        saw_done = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) saw_done = 1;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.opa   = 32'd0;
        bus.opb   = 32'd0;
`ifdef MDU_ABORT_EN
        bus.abort = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        check("rst_dz",   {63'd0, bus.div_by_zero}, 64'd0);
        rst_n = 1'b1;

        run_check("mult_neg3x5", 2'b01, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        check("done_one_cycle_busy", {63'd0, bus.busy}, 64'd0);
        @(posedge clk);
        #1;
        check("done_pulse_width", {63'd0, bus.done}, 64'd0);

        // Reset mid-operation clears results asynchronously and no done follows.
        launch(1'b1, 2'b01, 32'd7, 32'd9);
        repeat (9) @(posedge clk);
        #2;
        check("midop_busy_before", {63'd0, bus.busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("midop_rst_busy", {63'd0, bus.busy}, 64'd0);
        check("midop_rst_done", {63'd0, bus.done}, 64'd0);
        check("midop_rst_hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        watch_no_done(40);
        check("midop_no_done", 64'(saw_done), 64'd0);

        run_check("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_check("multu_zero", 2'b00, 32'd0, 32'h1234_5678, 32'd0, 32'd0, 1'b0);
        run_check("div_neg7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_check("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
        run_check("divu_100_7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run_check("divu_by0", 2'b10, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
        run_check("multu_2x3", 2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);
        run_check("div_7_neg2", 2'b11, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);

        // Second start while busy is ignored; operand changes after the start edge have no effect.
        launch(1'b1, 2'b10, 32'd50, 32'd6);
        repeat (4) @(posedge clk);
        bus.opa = 32'd99;
        bus.opb = 32'd1;
        launch(1'b0, 2'b00, 32'd11, 32'd13);
        t_start = t_start - 5;
        wait_done(t_done);
        check("busy_ign_lat", 64'(t_done - t_start), 64'd33);
        check("busy_ign_hilo", {bus.hi, bus.lo}, {32'd2, 32'd8});

        // Start held during the DONE cycle is accepted: done-to-done spacing is WIDTH+2.
        t_done_prev = t_done;
        launch(1'b0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(t_done);
        check("b2b_spacing", 64'(t_done - t_done_prev), 64'd34);
        check("b2b_hilo", {bus.hi, bus.lo}, 64'd1);

`ifdef MDU_ABORT_EN
        // Abort while calculating: no done, results retained.
        launch(1'b1, 2'b00, 32'd1000, 32'd1000);
        repeat (11) @(posedge clk);
        @(negedge clk);
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", {63'd0, bus.busy}, 64'd0);
        watch_no_done(40);
        check("abort_no_done", 64'(saw_done), 64'd0);
        check("abort_hilo", {bus.hi, bus.lo}, 64'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
